uart_tx_feeder: RTL

//  Upstream stage of the UART transmitter. Buffers processor writes in a FIFO and drives the

---
 rtl/uart_tx_feeder_pkg.sv | 21 ++
 rtl/uart_tx_feeder_if.sv | 25 ++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx_feeder.sv | 118 +++++++++++
 4 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder.
//  - fsm_state_t  : sequencing FSM encoding (IDLE / REQ / RUN)
//  - fifo_entry_t : one queued write, {word flag, 16-bit payload}
//  - DEPTH_DEF/AW_DEF : default FIFO geometry
package uart_tx_feeder_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int AW_DEF    = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RUN  = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic        word;
        logic [15:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Begin/data handshake between the feeder and the UART tx module.
//  tx_data         feeder -> tx : [15:8]=0, [7:0]=byte of the current frame
//  transmit_begin  feeder -> tx : frame request
//  transmit_active tx -> feeder : start accepted / frame in progress
//  transmit_over   tx -> feeder : frame finished (high at power-up)
interface uart_tx_feeder_if;
    logic [15:0] tx_data;
    logic        transmit_begin;
    logic        transmit_active;
    logic        transmit_over;

    modport master (
        output tx_data,
        output transmit_begin,
        input  transmit_active,
        input  transmit_over
    );

    modport slave (
        input  tx_data,
        input  transmit_begin,
        output transmit_active,
        output transmit_over
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding queued feeder writes.
//  s_tick, rst_n : clock, async active-low reset
//  push/wr_entry : write one entry (ignored when full)
//  pop/rd_entry  : rd_entry shows the head; pop advances it (ignored when empty)
//  flush         : empties the FIFO; wins over a same-tick push or pop
//  full, empty, level : occupancy status, level in 0..DEPTH
module uart_tx_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic        s_tick,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  fifo_entry_t wr_entry,
    output fifo_entry_t rd_entry,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign rd_entry = mem[rd_ptr];

    // Pointers are AW bits wide and wrap naturally because DEPTH == 2**AW.
    always_ff @(posedge s_tick or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge s_tick) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Upstream stage of the UART transmitter: buffers processor writes and
// feeds the tx module one 8-bit frame at a time. A word write becomes two
// frames, low byte first. tx_data is held stable for the whole frame.
//  s_tick, rst_n      : tx tick clock, async active-low reset
//  wr_en/wr_data/wr_word : queue a byte (wr_word=0) or a word (wr_word=1)
//  flush              : empty the queue and clear overflow; frame in flight completes
//  tx_if (master)     : begin/data handshake towards the tx module
//  full, empty, level : queue status
//  overflow           : sticky, set by a write while full, cleared by flush
//  busy               : a frame is being sequenced or the queue is non-empty
//
//  state | meaning
//  IDLE  | no frame owned; pops the next entry when the queue is non-empty
//  REQ   | transmit_begin high, waiting for tx to report transmit_active
//  RUN   | frame accepted, waiting for transmit_over
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              s_tick,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [15:0]       wr_data,
    input  logic              wr_word,
    input  logic              flush,
    uart_tx_feeder_if.master  tx_if,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic              busy
);

    fsm_state_t  state;
    fsm_state_t  state_nxt;
    fifo_entry_t wr_entry;
    fifo_entry_t head;
    logic        pop;
    logic        begin_c;
    logic        busy_c;
    logic [7:0]  cur_byte;
    logic [7:0]  hi_byte;
    logic        word_pend;

    assign wr_entry = {wr_word, wr_data};

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .s_tick   (s_tick),
        .rst_n    (rst_n),
        .push     (wr_en),
        .pop      (pop),
        .flush    (flush),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    always_ff @(posedge s_tick or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // RUN is only entered after transmit_active, so transmit_over has already
    // dropped by then and a stale power-up transmit_over cannot end a frame.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (!empty) state_nxt = S_REQ;
            S_REQ:  if (tx_if.transmit_active) state_nxt = S_RUN;
            S_RUN:  if (tx_if.transmit_over) state_nxt = word_pend ? S_REQ : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Begin is a pure state decode, so it is glitch-free and changes only on the tick edge.
    always_comb begin
        pop     = 1'b0;
        begin_c = 1'b0;
        busy_c  = 1'b0;
        if (state == S_IDLE && !empty) pop = 1'b1;
        if (state == S_REQ) begin_c = 1'b1;
        if (state != S_IDLE || !empty) busy_c = 1'b1;
    end

    assign tx_if.transmit_begin = begin_c;
    assign tx_if.tx_data        = {8'h00, cur_byte};
    assign busy                 = busy_c;

    // cur_byte only changes on leaving IDLE or RUN, never while tx owns it.
    always_ff @(posedge s_tick or negedge rst_n) begin
        if (!rst_n) begin
            cur_byte  <= '0;
            hi_byte   <= '0;
            word_pend <= 1'b0;
        end else if (pop) begin
            cur_byte  <= head.data[7:0];
            hi_byte   <= head.data[15:8];
            word_pend <= head.word;
        end else if (state == S_RUN && tx_if.transmit_over && word_pend) begin
            cur_byte  <= hi_byte;
            word_pend <= 1'b0;
        end
    end

    always_ff @(posedge s_tick or negedge rst_n) begin
        if (!rst_n)             overflow <= 1'b0;
        else if (flush)         overflow <= 1'b0;
        else if (wr_en && full) overflow <= 1'b1;
    end

endmodule
